sort_collector: RTL

Upstream feeder for the six-input combinational ascending sorter. Accepts a serial stream of 32-bit words over a valid/ready handshake and groups them into frames of up to six. Each completed frame is presented as six parallel words plus a word count on a frame-level valid/ready handshake, which drives the sorter's `a`..`f` inputs directly. Two frame buffers (ping-pong) let one frame be filled while the previous one is held for the sorter and its consumer.

---
 rtl/sort_pkg.sv | 15 +
 rtl/sort_collector_if.sv | 26 ++
 rtl/sort_bank.sv | 52 +++++
 rtl/sort_collector.sv | 103 ++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the six-input sorter front end.
// The frame-buffer struct mirrors what the collector holds per bank.
package sort_pkg;
    localparam int SORT_N = 6;
    localparam int SORT_W = 32;
    localparam logic [SORT_W-1:0] SORT_PAD = {SORT_W{1'b1}};

    typedef logic [SORT_W-1:0] sort_word_t;
    typedef logic [2:0]        sort_cnt_t;

    typedef struct packed {
        sort_word_t [SORT_N-1:0] word;
        sort_cnt_t               count;
    } sort_frame_t;
endpackage

// File: rtl/sort_collector_if.sv
// Word-stream input and frame-level output of the sort collector.
// The slave modport is the collector's own view.
interface sort_collector_if
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_W
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             frame_valid;
    logic             frame_ready;
    logic [WIDTH-1:0] a, b, c, d, e, f;
    sort_cnt_t        frame_count;

    modport master (
        output in_valid, in_data, in_last, frame_ready,
        input  in_ready, frame_valid, a, b, c, d, e, f, frame_count
    );

    modport slave (
        input  in_valid, in_data, in_last, frame_ready,
        output in_ready, frame_valid, a, b, c, d, e, f, frame_count
    );
endinterface

// File: rtl/sort_bank.sv
// One frame buffer: slot write, close-with-pad, synchronous clear, parallel read.
module sort_bank
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_W,
    parameter int N     = SORT_N
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  sort_cnt_t        wr_slot_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             close_i,
    output logic [WIDTH-1:0] word_o [N],
    output sort_cnt_t        count_o
);
    logic [WIDTH-1:0] word_q [N];
    logic [WIDTH-1:0] word_d [N];
    sort_cnt_t        count_q, count_d;

    // Slots past the closing word get all-ones so an ascending sort puts them last.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (wr_en_i) begin
            word_d[wr_slot_i] = wr_data_i;
            if (close_i) begin
                for (int i = 0; i < N; i++) begin
                    if (sort_cnt_t'(i) > wr_slot_i) begin
                        word_d[i] = {WIDTH{1'b1}};
                    end
                end
                count_d = wr_slot_i + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < N; i++) begin
                word_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign word_o  = word_q;
    assign count_o = count_q;
endmodule

// File: rtl/sort_collector.sv
// Groups a serial word stream into frames of up to six for the sorter,
// ping-ponging between two banks so filling overlaps with presentation.
module sort_collector
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_W,
    parameter int N     = SORT_N
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_collector_if.slave   bus
);
    localparam sort_cnt_t LAST_SLOT = sort_cnt_t'(N - 1);

    logic [1:0] full_q, full_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    sort_cnt_t  cnt_q, cnt_d;

    logic       in_ready;
    logic       frame_valid;
    logic       accept;
    logic       close;
    logic       frame_acc;

    logic [WIDTH-1:0] words0 [N];
    logic [WIDTH-1:0] words1 [N];
    sort_cnt_t        count0, count1;

    // A close on wb and an accept on rb never hit the same bank: close needs
    // full[wb]==0, accept needs full[rb]==1.
    always_comb begin
        in_ready    = !full_q[wb_q] && rst_n;
        frame_valid = full_q[rb_q];
        accept      = bus.in_valid && in_ready;
        close       = accept && (cnt_q == LAST_SLOT || bus.in_last);
        frame_acc   = frame_valid && bus.frame_ready;

        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        cnt_d  = cnt_q;

        if (close) begin
            full_d[wb_q] = 1'b1;
            wb_d         = !wb_q;
            cnt_d        = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 3'd1;
        end

        if (frame_acc) begin
            full_d[rb_q] = 1'b0;
            rb_d         = !rb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            cnt_q  <= cnt_d;
        end
    end

    sort_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
        .clk       (clk),
        .clr_i     (!rst_n),
        .wr_en_i   (accept && !wb_q),
        .wr_slot_i (cnt_q),
        .wr_data_i (bus.in_data),
        .close_i   (close),
        .word_o    (words0),
        .count_o   (count0)
    );

    sort_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
        .clk       (clk),
        .clr_i     (!rst_n),
        .wr_en_i   (accept && wb_q),
        .wr_slot_i (cnt_q),
        .wr_data_i (bus.in_data),
        .close_i   (close),
        .word_o    (words1),
        .count_o   (count1)
    );

    assign bus.in_ready    = in_ready;
    assign bus.frame_valid = frame_valid;
    assign bus.a           = rb_q ? words1[0] : words0[0];
    assign bus.b           = rb_q ? words1[1] : words0[1];
    assign bus.c           = rb_q ? words1[2] : words0[2];
    assign bus.d           = rb_q ? words1[3] : words0[3];
    assign bus.e           = rb_q ? words1[4] : words0[4];
    assign bus.f           = rb_q ? words1[5] : words0[5];
    assign bus.frame_count = rb_q ? count1 : count0;
endmodule
